conv_pass_sequencer: RTL and testbench

- Sequences the convolution layer over a multi-channel input feature map.
- For each input channel it resets the layer, streams the channel's MxM activations from activation BRAM (1-cycle read latency) and waits for the layer's done.
- Programs accumulate/save_to_ram so that channel 0 overwrites, channels 1..C-2 accumulate, and the final channel accumulates and saves.
- Sits between the layer-control register file and convolution_layer; drives the layer's run, reset and config fields.

---
 rtl/conv_pass_sequencer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_conv_pass_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pass_sequencer.sv
// conv_pass_sequencer
//   Runs the convolution layer once per input channel of a multi-channel
//   feature map.
//   Each pass does the following steps:
//     - resets the layer;
//     - streams the channel's MxM activations from the activation BRAM
//       (1-cycle read latency);
//     - waits for the layer's done.
//   Channel 0 overwrites the output, the middle channels accumulate, and the
//   last channel accumulates and saves to RAM.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, abort_i      sequence start (IDLE only) / abort (non-IDLE only)
//   channels_i            C, latched at start
//   matrix_size_i         M, latched at start
//   base_addr_i           activation base address, latched at start
//   act_rd_en_o           activation BRAM read enable
//   act_addr_o            activation BRAM read address
//   act_data_i            BRAM data, one cycle after the read
//   layer_rst_o           layer reset (also high while rst_i is high)
//   layer_run_o           layer run, aligned with layer_data_o
//   layer_data_o          registered activation word to the layer
//   accumulate_o          layer config: accumulate onto the previous result
//   save_to_ram_o         layer config: save the result on this pass
//   channel_o             current channel, selects the weight bank
//   layer_done_i          layer done status
//   busy_o                sequence active
//   done_o                one-cycle completion pulse
//   error_o               sticky error, cleared by the next accepted start
module conv_pass_sequencer #(
  parameter int MaxMatrixSize = 16383,
  parameter int MaxChannels   = 1024,
  parameter int KernelSize    = 3,
  parameter int N             = 16,
  parameter int TimeoutCycles = 65535,
  parameter int AddrW         = $clog2(64'(MaxMatrixSize) * 64'(MaxMatrixSize) * 64'(MaxChannels))
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             abort_i,
  input  logic [$clog2(MaxChannels+1)-1:0] channels_i,
  input  logic [13:0]                      matrix_size_i,
  input  logic [AddrW-1:0]                 base_addr_i,
  output logic                             act_rd_en_o,
  output logic [AddrW-1:0]                 act_addr_o,
  input  logic [N-1:0]                     act_data_i,
  output logic                             layer_rst_o,
  output logic                             layer_run_o,
  output logic [N-1:0]                     layer_data_o,
  output logic                             accumulate_o,
  output logic                             save_to_ram_o,
  output logic [$clog2(MaxChannels)-1:0]   channel_o,
  input  logic                             layer_done_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             error_o
);

  localparam int CW  = $clog2(MaxChannels + 1);
  localparam int CHW = $clog2(MaxChannels);
  localparam int PW  = 28;                        // width of M*M for a 14-bit M
  localparam int TW  = $clog2(TimeoutCycles + 1);

  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_ABORT  = 3'd5;

  logic [2:0]       r_state;
  logic [CW-1:0]    r_c;
  logic [PW-1:0]    r_mm;
  logic [CHW-1:0]   r_ch;
  logic [PW-1:0]    r_p;
  logic [AddrW-1:0] r_chan_base;
  logic [AddrW-1:0] r_addr;
  logic [TW-1:0]    r_tmo;
  logic             r_rd_en;
  logic             r_rd_d1;
  logic             r_got_first;
  logic             r_run;
  logic [N-1:0]     r_data;
  logic             r_lrst;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_acc;
  logic             r_save;

  logic [2:0]       w_next;
  logic             w_cfg_bad;
  logic             w_start_ok;
  logic             w_last_ch;
  logic             w_stream_end;
  logic             w_tmo_fire;
  logic [CHW-1:0]   w_ch_next;
  logic [CW-1:0]    w_c_eff;
  logic             w_save_next;
  logic [PW-1:0]    w_mm;

  // Start-parameter validation and per-pass status terms.
  // C above MaxChannels is also rejected: the channel register could never
  // reach C-1, so such a sequence would never finish.
  always_comb begin
    w_cfg_bad    = (channels_i == CW'(0))
                 || (channels_i > CW'(MaxChannels))
                 || (matrix_size_i < 14'(KernelSize))
                 || ({1'b0, matrix_size_i} > 15'(MaxMatrixSize));
    w_start_ok   = start_i && !w_cfg_bad;
    w_mm         = PW'(matrix_size_i) * PW'(matrix_size_i);
    w_last_ch    = (CW'(r_ch) == (r_c - CW'(1)));
    w_stream_end = (r_p == (r_mm - PW'(1)));
    w_tmo_fire   = (r_state == S_DRAIN) && !abort_i && !layer_done_i && (r_tmo == TMO_LAST);
  end

  // Next-state selection.
  // Priority order: abort first, then layer done, then timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next = S_CLEAR;
        else            w_next = S_IDLE;
      end
      S_CLEAR: begin
        if (abort_i) w_next = S_ABORT;
        else         w_next = S_STREAM;
      end
      S_STREAM: begin
        if (abort_i)           w_next = S_ABORT;
        else if (w_stream_end) w_next = S_DRAIN;
        else                   w_next = S_STREAM;
      end
      S_DRAIN: begin
        if (abort_i)           w_next = S_ABORT;
        else if (layer_done_i) w_next = w_last_ch ? S_FINISH : S_CLEAR;
        else if (w_tmo_fire)   w_next = S_ABORT;
        else                   w_next = S_DRAIN;
      end
      S_FINISH: begin
        if (abort_i) w_next = S_ABORT;
        else         w_next = S_IDLE;
      end
      S_ABORT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Channel index and config bits for the pass that the next CLEAR starts.
  // In IDLE, C comes straight from the input because it is being latched.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_ch_next = w_start_ok ? CHW'(0) : r_ch;
      w_c_eff   = channels_i;
    end else if ((r_state == S_DRAIN) && (w_next == S_CLEAR)) begin
      w_ch_next = r_ch + CHW'(1);
      w_c_eff   = r_c;
    end else begin
      w_ch_next = r_ch;
      w_c_eff   = r_c;
    end
    w_save_next = (CW'(w_ch_next) == (w_c_eff - CW'(1)));
  end

  // State register and registered control outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_lrst  <= 1'b0;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_lrst  <= (w_next == S_CLEAR) || (w_next == S_ABORT);
      r_rd_en <= (w_next == S_STREAM);
      r_done  <= (w_next == S_FINISH) || ((r_state == S_IDLE) && start_i && w_cfg_bad);
    end
  end

  // Latched sequence parameters, channel base, read address and pixel counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_c         <= '0;
      r_mm        <= '0;
      r_ch        <= '0;
      r_p         <= '0;
      r_chan_base <= '0;
      r_addr      <= '0;
    end else begin
      r_ch <= w_ch_next;
      if ((r_state == S_IDLE) && w_start_ok) begin
        r_c         <= channels_i;
        r_mm        <= w_mm;
        r_chan_base <= base_addr_i;
      end else if ((r_state == S_DRAIN) && (w_next == S_CLEAR)) begin
        r_chan_base <= r_chan_base + AddrW'(r_mm);
      end else begin
        r_chan_base <= r_chan_base;
      end
      // r_addr tracks base + ch*M*M + p without a multiplier.
      if (r_state == S_STREAM) begin
        r_p    <= r_p + PW'(1);
        r_addr <= r_addr + AddrW'(1);
      end else if (r_state == S_CLEAR) begin
        r_p    <= '0;
        r_addr <= r_chan_base;
      end else begin
        r_p    <= '0;
        r_addr <= r_addr;
      end
    end
  end

  // Activation datapath.
  // Read data returns one cycle after the read and is then registered, so
  // run follows the read enable by two register stages; it stays high in
  // DRAIN once the first word has arrived.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_d1     <= 1'b0;
      r_data      <= '0;
      r_run       <= 1'b0;
      r_got_first <= 1'b0;
    end else begin
      r_rd_d1 <= r_rd_en;
      r_data  <= act_data_i;
      r_run   <= ((w_next == S_STREAM) || (w_next == S_DRAIN))
              && (r_rd_d1 || ((w_next == S_DRAIN) && r_got_first));
      if (w_next == S_CLEAR) r_got_first <= 1'b0;
      else if (r_rd_d1)      r_got_first <= 1'b1;
      else                   r_got_first <= r_got_first;
    end
  end

  // Per-pass layer config.
  // The bits are loaded on entry to CLEAR and then held through DRAIN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc  <= 1'b0;
      r_save <= 1'b0;
    end else if (w_next == S_CLEAR) begin
      r_acc  <= (w_ch_next != CHW'(0));
      r_save <= w_save_next;
    end else begin
      r_acc  <= r_acc;
      r_save <= r_save;
    end
  end

  // DRAIN timeout counter, re-armed whenever DRAIN is left.
  always_ff @(posedge clk_i) begin
    if (rst_i)                  r_tmo <= '0;
    else if (r_state == S_DRAIN) r_tmo <= r_tmo + TW'(1);
    else                        r_tmo <= '0;
  end

  // Sticky error flag.
  // Any start seen in IDLE rewrites it with that start's validity.
  always_ff @(posedge clk_i) begin
    if (rst_i)                              r_err <= 1'b0;
    else if ((r_state == S_IDLE) && start_i) r_err <= w_cfg_bad;
    else if (w_tmo_fire)                    r_err <= 1'b1;
    else                                    r_err <= r_err;
  end

  assign act_rd_en_o   = r_rd_en;
  assign act_addr_o    = r_addr;
  assign layer_rst_o   = r_lrst | rst_i;
  assign layer_run_o   = r_run;
  assign layer_data_o  = r_data;
  assign accumulate_o  = r_acc;
  assign save_to_ram_o = r_save;
  assign channel_o     = r_ch;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign error_o       = r_err;

endmodule

// File: tb/tb_conv_pass_sequencer.sv
module tb_conv_pass_sequencer;
  localparam int AW   = 38;
  localparam int TMO  = 20;
  localparam int MAXC = 1500;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [10:0]   channels_i = 11'd0;
  logic [13:0]   matrix_size_i = 14'd0;
  logic [AW-1:0] base_addr_i = '0;
  logic          act_rd_en_o;
  logic [AW-1:0] act_addr_o;
  logic [15:0]   act_data_i = 16'h0;
  logic          layer_rst_o, layer_run_o;
  logic [15:0]   layer_data_o;
  logic          accumulate_o, save_to_ram_o;
  logic [9:0]    channel_o;
  logic          layer_done_i = 1'b0;
  logic          busy_o, done_o, error_o;

  int total = 0;
  int bad = 0;

  conv_pass_sequencer #(.TimeoutCycles(TMO), .AddrW(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .channels_i(channels_i), .matrix_size_i(matrix_size_i), .base_addr_i(base_addr_i),
    .act_rd_en_o(act_rd_en_o), .act_addr_o(act_addr_o), .act_data_i(act_data_i),
    .layer_rst_o(layer_rst_o), .layer_run_o(layer_run_o), .layer_data_o(layer_data_o),
    .accumulate_o(accumulate_o), .save_to_ram_o(save_to_ram_o), .channel_o(channel_o),
    .layer_done_i(layer_done_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  // Activation BRAM model: word content derived from the address, 1-cycle latency.
  logic [15:0] seed = 16'h0;
  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ seed;
  endfunction
  always @(posedge clk) if (act_rd_en_o) act_data_i <= mem_word(act_addr_o);

  // Per-cycle trace of one sequence, sampled on the falling edge.
  logic        tr_run[MAXC], tr_lrst[MAXC], tr_busy[MAXC], tr_done[MAXC], tr_err[MAXC], tr_rd[MAXC];
  logic [15:0] tr_data[MAXC];
  int          fr[$];
  logic [AW-1:0] rd_addr[$];
  int          rd_ch[$];
  logic        rd_acc[$], rd_sav[$];
  int          n_clear, n_done, done_cyc, drv_cyc, drain_cyc, abort_cyc;

  // Start one sequence and record everything until busy drops again.
  // dly < 0 means layer_done_i is never answered.
  task automatic run_seq(input int c, input int m, input logic [AW-1:0] base, input int dly,
                         input int abort_at, input int restart_at);
    int cyc = 0;
    int cnt = -1;
    logic prev_rd = 1'b0;
    logic prev_lrst = 1'b0;
    logic fin = 1'b0;
    fr.delete(); rd_addr.delete(); rd_ch.delete(); rd_acc.delete(); rd_sav.delete();
    n_clear = 0; n_done = 0; done_cyc = 0; drv_cyc = 0; drain_cyc = 0; abort_cyc = 0;
    @(negedge clk);
    channels_i = 11'(c); matrix_size_i = 14'(m); base_addr_i = base; start_i = 1'b1;
    while (!fin && cyc < MAXC) begin
      @(negedge clk);
      start_i = 1'b0; abort_i = 1'b0; layer_done_i = 1'b0;
      tr_run[cyc] = layer_run_o; tr_lrst[cyc] = layer_rst_o; tr_busy[cyc] = busy_o;
      tr_done[cyc] = done_o; tr_err[cyc] = error_o; tr_rd[cyc] = act_rd_en_o;
      tr_data[cyc] = layer_data_o;
      if (act_rd_en_o) begin
        if (!prev_rd) fr.push_back(cyc);
        rd_addr.push_back(act_addr_o); rd_ch.push_back(int'(channel_o));
        rd_acc.push_back(accumulate_o); rd_sav.push_back(save_to_ram_o);
        if (rd_addr.size() - 1 == abort_at) begin abort_i = 1'b1; abort_cyc = cyc; end
        if (rd_addr.size() - 1 == restart_at) begin
          start_i = 1'b1; channels_i = 11'(c + 2); matrix_size_i = 14'(m + 3); base_addr_i = base + AW'(7);
        end
      end
      if (prev_rd && !act_rd_en_o) begin drain_cyc = cyc; cnt = dly; end
      if (cnt == 0) begin layer_done_i = 1'b1; drv_cyc = cyc; end
      if (cnt >= 0) cnt--;
      if (layer_rst_o && !prev_lrst) n_clear++;
      if (done_o) begin n_done++; done_cyc = cyc; end
      prev_rd = act_rd_en_o; prev_lrst = layer_rst_o;
      if (!busy_o && cyc > 0) fin = 1'b1;
      cyc++;
    end
    start_i = 1'b0; abort_i = 1'b0; layer_done_i = 1'b0;
    total++;
    if (!fin) begin bad++; $display("FAIL run_seq_budget cycles=%0d required busy to drop", cyc); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({layer_rst_o, busy_o, done_o, error_o, act_rd_en_o, layer_run_o, accumulate_o, save_to_ram_o} !== 8'b1000_0000
        || channel_o !== 10'd0 || act_addr_o !== '0) begin
      bad++; $display("FAIL reset_outputs got rst=%b busy=%b done=%b err=%b rd=%b run=%b", layer_rst_o, busy_o, done_o, error_o, act_rd_en_o, layer_run_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    total++;
    if (layer_rst_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL reset_release got layer_rst=%b busy=%b required 0 0", layer_rst_o, busy_o);
    end
    // Reset in the middle of a stream returns to IDLE without a done pulse.
    channels_i = 11'd2; matrix_size_i = 14'd4; base_addr_i = AW'(40); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (busy_o !== 1'b1 || act_rd_en_o !== 1'b1) begin
      bad++; $display("FAIL midreset_pre got busy=%b rd=%b required 1 1", busy_o, act_rd_en_o);
    end
    rst_i = 1'b1;
    @(negedge clk);
    total++;
    if ({layer_rst_o, busy_o, act_rd_en_o, done_o} !== 4'b1000) begin
      bad++; $display("FAIL midreset_during got rst,busy,rd,done=%b required 1000", {layer_rst_o, busy_o, act_rd_en_o, done_o});
    end
    rst_i = 1'b0;
    @(negedge clk);
    total++;
    if ({layer_rst_o, busy_o, done_o} !== 3'b000) begin
      bad++; $display("FAIL midreset_after got rst,busy,done=%b required 000", {layer_rst_o, busy_o, done_o});
    end
  endtask

  // Normal sequences: plan cases, a restart-while-busy case and random ones.
  task automatic test_sequences();
    for (int s = 0; s < 8; s++) begin
      int c, m, mm, dly, rs;
      logic [AW-1:0] base;
      if (s == 0)      begin c = 1; m = 5; base = '0;      dly = 10; rs = -1; seed = 16'h0; end
      else if (s == 1) begin c = 3; m = 5; base = AW'(100); dly = 4; rs = -1; seed = 16'($urandom); end
      else if (s == 2) begin c = 2; m = 4; base = AW'(300); dly = 3; rs = 5;  seed = 16'($urandom); end
      else begin
        c = $urandom_range(1, 4); m = $urandom_range(3, 6);
        base = AW'($urandom_range(0, 1000000)); dly = $urandom_range(2, 8); rs = -1;
        seed = 16'($urandom);
      end
      mm = m * m;
      run_seq(c, m, base, dly, -1, rs);
      total++;
      if (rd_addr.size() != c * mm || fr.size() != c) begin
        bad++; $display("FAIL seq%0d_reads got %0d in %0d bursts required %0d in %0d", s, rd_addr.size(), fr.size(), c * mm, c);
      end
      total++;
      if (n_clear != c || n_done != 1) begin
        bad++; $display("FAIL seq%0d_pulses got clears=%0d dones=%0d required %0d 1", s, n_clear, n_done, c);
      end
      total++;
      if (tr_done[drv_cyc + 1] !== 1'b1 || {tr_busy[drv_cyc + 1], tr_busy[drv_cyc + 2]} !== 2'b10) begin
        bad++; $display("FAIL seq%0d_done_timing got done=%b busy=%b%b required 1 10", s, tr_done[drv_cyc + 1], tr_busy[drv_cyc + 1], tr_busy[drv_cyc + 2]);
      end
      if (rd_addr.size() == c * mm && fr.size() == c) begin
        for (int i = 0; i < c; i++) begin
          total++;
          if (tr_run[fr[i] + 1] !== 1'b0) begin
            bad++; $display("FAIL seq%0d_run_early pass=%0d got 1 required 0", s, i);
          end
          for (int k = 0; k < mm; k++) begin
            int idx = i * mm + k;
            logic [AW-1:0] ea;
            ea = base + AW'(idx);
            total++;
            if (rd_addr[idx] !== ea || rd_ch[idx] != i || rd_acc[idx] !== (i != 0) || rd_sav[idx] !== (i == c - 1)) begin
              bad++; $display("FAIL seq%0d_read pass=%0d p=%0d got addr=%0d ch=%0d acc=%b sav=%b required addr=%0d ch=%0d acc=%b sav=%b",
                              s, i, k, rd_addr[idx], rd_ch[idx], rd_acc[idx], rd_sav[idx], ea, i, (i != 0), (i == c - 1));
            end
            total++;
            if (tr_run[fr[i] + 2 + k] !== 1'b1 || tr_data[fr[i] + 2 + k] !== mem_word(ea)) begin
              bad++; $display("FAIL seq%0d_data pass=%0d p=%0d got run=%b data=%h required 1 %h",
                              s, i, k, tr_run[fr[i] + 2 + k], tr_data[fr[i] + 2 + k], mem_word(ea));
            end
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [AW-1:0] b2;
    seed = 16'($urandom);
    run_seq(3, 5, AW'(500), 3, 25 + 12, -1);
    total++;
    if (n_done != 0 || rd_addr.size() != 38) begin
      bad++; $display("FAIL abort_counts got dones=%0d reads=%0d required 0 38", n_done, rd_addr.size());
    end
    total++;
    if ({tr_lrst[abort_cyc + 1], tr_rd[abort_cyc + 1], tr_run[abort_cyc + 1], tr_busy[abort_cyc + 1]} !== 4'b1001) begin
      bad++; $display("FAIL abort_state got rst,rd,run,busy=%b required 1001",
                      {tr_lrst[abort_cyc + 1], tr_rd[abort_cyc + 1], tr_run[abort_cyc + 1], tr_busy[abort_cyc + 1]});
    end
    total++;
    if (tr_busy[abort_cyc + 2] !== 1'b0 || tr_lrst[abort_cyc + 2] !== 1'b0) begin
      bad++; $display("FAIL abort_idle got busy=%b rst=%b required 0 0", tr_busy[abort_cyc + 2], tr_lrst[abort_cyc + 2]);
    end
    b2 = AW'($urandom_range(0, 5000));
    run_seq(1, 4, b2, 2, -1, -1);
    total++;
    if (n_done != 1 || rd_addr.size() != 16 || n_clear != 1) begin
      bad++; $display("FAIL abort_rerun got dones=%0d reads=%0d clears=%0d required 1 16 1", n_done, rd_addr.size(), n_clear);
    end
    total++;
    if (rd_addr.size() == 16 && (rd_addr[0] !== b2 || rd_addr[15] !== b2 + AW'(15) || rd_sav[0] !== 1'b1)) begin
      bad++; $display("FAIL abort_rerun_addr got first=%0d last=%0d required %0d %0d", rd_addr[0], rd_addr[15], b2, b2 + AW'(15));
    end
  endtask

  task automatic test_timeout();
    run_seq(1, 3, AW'(77), -1, -1, -1);
    total++;
    if (tr_err[drain_cyc + TMO - 1] !== 1'b0 || tr_err[drain_cyc + TMO] !== 1'b1) begin
      bad++; $display("FAIL timeout_err got %b%b required 01", tr_err[drain_cyc + TMO - 1], tr_err[drain_cyc + TMO]);
    end
    total++;
    if (tr_lrst[drain_cyc + TMO] !== 1'b1 || tr_run[drain_cyc + TMO] !== 1'b0 || tr_busy[drain_cyc + TMO + 1] !== 1'b0) begin
      bad++; $display("FAIL timeout_abort got rst=%b run=%b busy_after=%b required 1 0 0",
                      tr_lrst[drain_cyc + TMO], tr_run[drain_cyc + TMO], tr_busy[drain_cyc + TMO + 1]);
    end
    total++;
    if (n_done != 0) begin bad++; $display("FAIL timeout_done got %0d required 0", n_done); end
    @(negedge clk);
    total++;
    if (error_o !== 1'b1) begin bad++; $display("FAIL timeout_sticky got %b required 1", error_o); end
    run_seq(1, 3, AW'(77), 2, -1, -1);
    total++;
    if (tr_err[0] !== 1'b0 || n_done != 1) begin
      bad++; $display("FAIL timeout_clear got err=%b dones=%0d required 0 1", tr_err[0], n_done);
    end
  endtask

  task automatic test_bad_start();
    for (int t = 0; t < 2; t++) begin
      if (t == 0) run_seq(0, 5, AW'(10), 2, -1, -1);
      else        run_seq(2, 2, AW'(10), 2, -1, -1);
      total++;
      if ({tr_done[0], tr_err[0], tr_busy[0], tr_done[1]} !== 4'b1100) begin
        bad++; $display("FAIL bad_start%0d got done,err,busy,done_next=%b required 1100", t, {tr_done[0], tr_err[0], tr_busy[0], tr_done[1]});
      end
      total++;
      if (rd_addr.size() != 0 || n_clear != 0) begin
        bad++; $display("FAIL bad_start%0d_reads got reads=%0d clears=%0d required 0 0", t, rd_addr.size(), n_clear);
      end
    end
    // abort_i in IDLE has no effect.
    abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_o, layer_rst_o, error_o} !== 3'b001) begin
      bad++; $display("FAIL idle_abort got busy,rst,err=%b required 001", {busy_o, layer_rst_o, error_o});
    end
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_abort();
    test_timeout();
    test_bad_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
